// File: rtl/clk_div_monitor_if.sv
// Port bundle for clk_div_monitor: control and divided-clock inputs, measurement results out.
// The master modport is the driving side (bench or host); the slave modport is the monitor.
interface clk_div_monitor_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             en;
  logic             clr;
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             meas_err;
  logic             lock;
  logic [7:0]       err_count;

  modport master (
    output en, clr, div_in,
    input  period, high_time, meas_valid, meas_err, lock, err_count
  );

  modport slave (
    input  en, clr, div_in,
    output period, high_time, meas_valid, meas_err, lock, err_count
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled in the clk domain, flags ratio/duty
// errors, and tracks lock. Define CLK_DIV_MONITOR_SYNC_EN to add a 2-flop input synchroniser.
module clk_div_monitor #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DIV_RATIO = 6,
  parameter int unsigned LOCK_CNT  = 4
) (
  input logic              clk,
  input logic              rst,
  clk_div_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] Ratio   = CNT_W'(DIV_RATIO);
  localparam logic [CNT_W-1:0] HiFloor = CNT_W'(DIV_RATIO / 2);
  localparam logic [CNT_W-1:0] HiCeil  = CNT_W'((DIV_RATIO + 1) / 2);
  localparam logic [3:0]       LockMax = 4'(LOCK_CNT);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e           r_state;
  logic             r_s_q;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [3:0]       r_good_cnt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_meas_valid;
  logic             r_meas_err;
  logic             r_lock;
  logic [7:0]       r_err_count;

  logic             w_s;
  logic             w_rise;
  logic             w_good;
  logic [3:0]       w_good_nxt;

`ifdef CLK_DIV_MONITOR_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.div_in};
    end
  end

  assign w_s = r_sync[1];
`else
  assign w_s = bus.div_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s_q <= 1'b0;
    end else begin
      r_s_q <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_q;

  always_comb begin
    w_good     = (r_per_cnt == Ratio) && ((r_hi_cnt == HiFloor) || (r_hi_cnt == HiCeil));
    w_good_nxt = (r_good_cnt == LockMax) ? r_good_cnt : r_good_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StIdle;
      r_per_cnt    <= '0;
      r_hi_cnt     <= '0;
      r_good_cnt   <= '0;
      r_period     <= '0;
      r_high_time  <= '0;
      r_meas_valid <= 1'b0;
      r_meas_err   <= 1'b0;
      r_lock       <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_meas_err   <= 1'b0;
      if (!bus.en) begin
        // Results are kept; only the in-flight measurement and lock history are dropped.
        r_state    <= StIdle;
        r_per_cnt  <= '0;
        r_hi_cnt   <= '0;
        r_good_cnt <= '0;
        r_lock     <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: r_state <= StArm;
          StArm: begin
            if (w_rise) begin
              r_per_cnt <= CNT_W'(1);
              r_hi_cnt  <= CNT_W'(1);
              r_state   <= StMeasure;
            end
          end
          StMeasure: begin
            if (w_rise) begin
              r_period     <= r_per_cnt;
              r_high_time  <= r_hi_cnt;
              r_meas_valid <= 1'b1;
              r_per_cnt    <= CNT_W'(1);
              r_hi_cnt     <= CNT_W'(1);
              if (w_good) begin
                r_good_cnt <= w_good_nxt;
                r_lock     <= (w_good_nxt == LockMax);
              end else begin
                r_meas_err <= 1'b1;
                r_good_cnt <= '0;
                r_lock     <= 1'b0;
              end
            end else if (r_per_cnt == CntMax) begin
              // Stuck input: report once and re-arm on the next edge.
              r_meas_err <= 1'b1;
              r_good_cnt <= '0;
              r_lock     <= 1'b0;
              r_per_cnt  <= '0;
              r_hi_cnt   <= '0;
              r_state    <= StArm;
            end else begin
              r_per_cnt <= r_per_cnt + CNT_W'(1);
              if (w_s && (r_hi_cnt != CntMax)) begin
                r_hi_cnt <= r_hi_cnt + CNT_W'(1);
              end
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  // Counts the visible meas_err pulse, so clr during that pulse leaves exactly 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (bus.clr) begin
      r_err_count <= {7'd0, r_meas_err};
    end else if (r_meas_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign bus.period     = r_period;
  assign bus.high_time  = r_high_time;
  assign bus.meas_valid = r_meas_valid;
  assign bus.meas_err   = r_meas_err;
  assign bus.lock       = r_lock;
  assign bus.err_count  = r_err_count;

endmodule
